// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings and small helpers for the interconnect blocks.
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } hburst_t;

  // Remaining beats after the NONSEQ; undefined-length INCR counts as zero
  // so that it never holds the counter busy.
  function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
    logic [3:0] beats;
    case (hburst)
      WRAP4,  INCR4:  beats = 4'd3;
      WRAP8,  INCR8:  beats = 4'd7;
      WRAP16, INCR16: beats = 4'd15;
      default:        beats = 4'd0;
    endcase
    return beats;
  endfunction

  // Binary index of a one-hot vector (up to 32 bits wide).
  function automatic logic [4:0] onehot2idx(input logic [31:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ahb3lite_interconnect_arbiter_if.sv
// Request and grant bundle between the masters' address phases and one
// slave-port arbiter.
interface ahb3lite_interconnect_arbiter_if #(
  parameter int MASTERS     = 3,
  parameter int PRI_BITS    = ($clog2(MASTERS) > 0) ? $clog2(MASTERS) : 1,
  parameter int MASTER_BITS = ($clog2(MASTERS) > 0) ? $clog2(MASTERS) : 1
);

  logic [MASTERS-1:0]               req_hsel;
  logic [MASTERS-1:0][PRI_BITS-1:0] req_priority;
  logic [MASTERS-1:0][1:0]          req_htrans;
  logic [MASTERS-1:0][2:0]          req_hburst;
  logic [MASTERS-1:0]               req_hmastlock;
  logic                             slv_HREADY;

  logic [MASTERS-1:0]               grant;
  logic [MASTER_BITS-1:0]           grant_idx;
  logic [MASTER_BITS-1:0]           grant_idx_dly;
  logic                             burst_active;
  logic                             locked;

  modport master (
    output req_hsel, req_priority, req_htrans, req_hburst, req_hmastlock, slv_HREADY,
    input  grant, grant_idx, grant_idx_dly, burst_active, locked
  );

  modport slave (
    input  req_hsel, req_priority, req_htrans, req_hburst, req_hmastlock, slv_HREADY,
    output grant, grant_idx, grant_idx_dly, burst_active, locked
  );

endinterface

// File: rtl/ahb3lite_interconnect_rr_select.sv
// Round-robin pick: first candidate after the last winner, wrapping.
// Purely combinational; shared with the master-port arbiter.
module ahb3lite_interconnect_rr_select #(
  parameter int N    = 3,
  parameter int IDXW = ($clog2(N) > 0) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    cand,
  input  logic [IDXW-1:0] last,
  output logic [N-1:0]    win
);

  logic found;

  // Scan offsets 1..N from the last winner; the last winner itself is checked last.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int o = 1; o <= N; o++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && cand[j] && (j == ((int'(last) + o) % N))) begin
          win[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ahb3lite_interconnect_arbiter.sv
// Slave-port arbiter: priority first, round-robin within a level, with
// ownership changes held off during bursts and locked sequences.
module ahb3lite_interconnect_arbiter
  import ahb3lite_pkg::*;
#(
  parameter int MASTERS     = 3,
  parameter int PRI_BITS    = ($clog2(MASTERS) > 0) ? $clog2(MASTERS) : 1,
  parameter int MASTER_BITS = ($clog2(MASTERS) > 0) ? $clog2(MASTERS) : 1
) (
  input logic HCLK,
  input logic HRESET,
  ahb3lite_interconnect_arbiter_if.slave bus
);

  localparam int NLVL = 1 << PRI_BITS;

  logic [MASTERS-1:0]     grant_q;
  logic [MASTER_BITS-1:0] grant_idx_q;
  logic [MASTER_BITS-1:0] grant_idx_dly_q;
  logic [3:0]             cnt;
  logic                   locked_q;
  logic [MASTER_BITS-1:0] last_q [NLVL];

  logic                   sel_g;
  logic [1:0]             trans_g;
  logic [2:0]             burst_g;
  logic                   lock_g;
  logic                   accept;
  logic                   can_switch;

  logic [PRI_BITS-1:0]    lvl;
  logic [MASTERS-1:0]     cand;
  logic [MASTERS-1:0]     winner;
  logic [MASTERS-1:0]     next_grant;
  logic [MASTER_BITS-1:0] next_idx;

  assign sel_g   = bus.req_hsel[grant_idx_q];
  assign trans_g = bus.req_htrans[grant_idx_q];
  assign burst_g = bus.req_hburst[grant_idx_q];
  assign lock_g  = bus.req_hmastlock[grant_idx_q];

  assign accept = bus.slv_HREADY && sel_g && ((trans_g == NONSEQ) || (trans_g == SEQ));

  // SEQ/BUSY from the owner never releases the port, even for undefined INCR.
  assign can_switch = !sel_g || (trans_g == IDLE) ||
                      ((trans_g == NONSEQ) && (cnt == 4'd0) && !locked_q && !lock_g);

  // Highest requested priority level and the masters sitting at it.
  always_comb begin
    lvl  = '0;
    cand = '0;
    for (int m = 0; m < MASTERS; m++) begin
      if (bus.req_hsel[m] && (bus.req_priority[m] > lvl)) lvl = bus.req_priority[m];
    end
    for (int m = 0; m < MASTERS; m++) begin
      cand[m] = bus.req_hsel[m] && (bus.req_priority[m] == lvl);
    end
  end

  ahb3lite_interconnect_rr_select #(
    .N    (MASTERS),
    .IDXW (MASTER_BITS)
  ) u_rr_select (
    .cand (cand),
    .last (last_q[lvl]),
    .win  (winner)
  );

  // With no requester the port parks on its current owner.
  always_comb begin
    next_grant = (cand != '0) ? winner : grant_q;
    next_idx   = MASTER_BITS'(onehot2idx(32'(next_grant)));
  end

  // Grant, beat counter, lock tracking and round-robin history; all frozen while HREADY is low.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      grant_q         <= MASTERS'(1);
      grant_idx_q     <= '0;
      grant_idx_dly_q <= '0;
      cnt             <= '0;
      locked_q        <= 1'b0;
      for (int l = 0; l < NLVL; l++) last_q[l] <= '0;
    end else if (bus.slv_HREADY) begin
      grant_idx_dly_q <= grant_idx_q;

      if (!sel_g)                                           cnt <= '0;
      else if (accept && (trans_g == NONSEQ))               cnt <= burst_beats(burst_g);
      else if (accept && (trans_g == SEQ) && (cnt != 4'd0)) cnt <= cnt - 4'd1;

      if (accept && lock_g)        locked_q <= 1'b1;
      else if (!lock_g || !sel_g)  locked_q <= 1'b0;

      if (can_switch) begin
        grant_q     <= next_grant;
        grant_idx_q <= next_idx;
        if (cand != '0) last_q[lvl] <= next_idx;
      end
    end
  end

  assign bus.grant         = grant_q;
  assign bus.grant_idx     = grant_idx_q;
  assign bus.grant_idx_dly = grant_idx_dly_q;
  assign bus.burst_active  = (cnt != 4'd0);
  assign bus.locked        = locked_q;

endmodule
